bias_stream_unpacker: RTL

- Downstream consumer of the 64-bit bias buffer.
- Once the buffer reports loaded, the block reads the buffer word by word and splits each word into four signed 16-bit biases.
- Each bias is sign-extended and delivered as a per-output-channel valid/ready stream to the convolution accumulator's bias-add stage.
- One run is started per layer and covers exactly num_ch channels.

---
 rtl/bias_stream_unpacker_pkg.sv | 28 ++
 rtl/bias_stream_unpacker.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bias_stream_unpacker_pkg.sv
// Shared types, constants and the lane-select helper for the bias stream unpacker.
package bias_stream_unpacker_pkg;

    localparam int WORD_W = 64;                  // buffer word width
    localparam int BIAS_W = 16;                  // one packed bias
    localparam int LANES  = WORD_W / BIAS_W;     // biases per buffer word
    localparam int OUT_W  = 32;                  // bias width after sign extension
    localparam int CH_W   = 16;                  // channel counter / num_ch width
    localparam int LANE_W = $clog2(LANES);       // lane index width

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LAT,
        EMIT,
        DONE
    } state_e;

    // Pick one packed bias out of a buffer word (lane 0 = least significant
    // bits) and sign-extend it to the output width.
    function automatic logic [OUT_W-1:0] lane_bias(input logic [WORD_W-1:0] word,
                                                   input logic [LANE_W-1:0] lane);
        logic [BIAS_W-1:0] raw;
        raw = word[int'(lane)*BIAS_W +: BIAS_W];
        return {{(OUT_W-BIAS_W){raw[BIAS_W-1]}}, raw};
    endfunction

endpackage

// File: rtl/bias_stream_unpacker.sv
// Reads packed 64-bit bias words from the bias buffer and emits one
// sign-extended bias per output channel on a valid/ready stream.
module bias_stream_unpacker
    import bias_stream_unpacker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   num_ch,
    input  logic              buf_full,
    output logic              buf_rd_en,
    input  logic [WORD_W-1:0] buf_dout,
    output logic              bias_valid,
    input  logic              bias_ready,
    output logic [OUT_W-1:0]  bias_data,
    output logic              bias_last,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     num_ch_q;
    logic [CH_W-1:0]     ch_cnt_q;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   word_q;
    logic                is_last;

    // The current channel is the final one of the run; ch_cnt never passes
    // num_ch_q-1, so the full 16-bit channel range completes without wrapping.
    assign is_last = (ch_cnt_q == (num_ch_q - CH_W'(1)));

    // Next-state and output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        buf_rd_en  = 1'b0;
        bias_valid = 1'b0;
        bias_data  = '0;
        bias_last  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (num_ch == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                // Only the request waits on the buffer; later stages ignore buf_full.
                if (buf_full) begin
                    buf_rd_en = 1'b1;
                    state_d   = LAT;
                end
            end
            LAT: begin
                state_d = EMIT;
            end
            EMIT: begin
                bias_valid = 1'b1;
                bias_data  = lane_bias(word_q, lane_q);
                bias_last  = is_last;
                if (bias_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else if (lane_q == LANE_W'(LANES-1)) begin
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are quiet for the whole reset cycle, so an abort cannot
        // leak one more read strobe or bias.
        if (rst) begin
            buf_rd_en  = 1'b0;
            bias_valid = 1'b0;
            bias_data  = '0;
            bias_last  = 1'b0;
            busy       = 1'b0;
            done       = 1'b0;
        end
    end

    // State register plus run bookkeeping: channel count, lane and word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= IDLE;
            num_ch_q <= '0;
            ch_cnt_q <= '0;
            lane_q   <= '0;
            // NOTE: word_q is cleared with the rest of the state so nothing
            // left over from an aborted run can reach bias_data.
            word_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start && (num_ch != '0)) begin
                        num_ch_q <= num_ch;
                        ch_cnt_q <= '0;
                        lane_q   <= '0;
                    end
                end
                LAT: begin
                    word_q <= buf_dout;
                    lane_q <= '0;
                end
                EMIT: begin
                    if (bias_ready && !is_last) begin
                        ch_cnt_q <= ch_cnt_q + CH_W'(1);
                        lane_q   <= lane_q + LANE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
